spi_controller: RTL and testbench

- SPI controller (initiator) for the FPGA-side SPI link. It drives cs, sclk and sdo, and captures sdi.
- It generates one framed transfer of WIDTH bits per start request, full-duplex, MSB first.
- Protocol is SPI mode 0: sclk idles low, data launched on sclk falling edges, sampled on sclk rising edges.
- cs is active-high and frames the whole transfer. Peripherals latch the frame when cs falls.

---
 rtl/spi_controller.sv | 150 +++++++++++++++
 tb/tb_spi_controller.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: one framed, full-duplex, MSB-first transfer of WIDTH bits per start.
// cs is active-high around the frame, with CLK_DIV cycles of setup and hold around the sclk burst.
module spi_controller #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             cs,
    output logic             sclk,
    output logic             sdo,
    input  logic             sdi
);

    localparam int unsigned DIV_W  = $clog2(CLK_DIV) + 1;
    localparam int unsigned EDGE_W = $clog2(2 * WIDTH) + 1;
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        DONE
    } state_t;

    state_t             state, state_d;
    logic [DIV_W-1:0]   div_cnt, div_cnt_d;
    logic [EDGE_W-1:0]  edge_cnt, edge_cnt_d;
    logic [WIDTH-1:0]   tx_shift, tx_shift_d;
    logic [WIDTH-1:0]   rx_shift, rx_shift_d;
    logic [WIDTH-1:0]   rx_data_d;
    logic [WIDTH-1:0]   tx_next;
    logic               cs_d, sclk_d, sdo_d, done_d, busy_d;
    logic               div_last;

    // State and all outputs registered; reset is synchronous and overrides any transfer
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            cs       <= 1'b0;
            sclk     <= 1'b0;
            sdo      <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            div_cnt  <= div_cnt_d;
            edge_cnt <= edge_cnt_d;
            tx_shift <= tx_shift_d;
            rx_shift <= rx_shift_d;
            rx_data  <= rx_data_d;
            cs       <= cs_d;
            sclk     <= sclk_d;
            sdo      <= sdo_d;
            done     <= done_d;
            busy     <= busy_d;
        end
    end

    assign div_last = (div_cnt == DIV_LAST);
    assign tx_next  = tx_shift << 1;

    // Next-state and next-output logic
    always_comb begin
        state_d    = state;
        div_cnt_d  = div_cnt;
        edge_cnt_d = edge_cnt;
        tx_shift_d = tx_shift;
        rx_shift_d = rx_shift;
        rx_data_d  = rx_data;
        cs_d       = cs;
        sclk_d     = sclk;
        sdo_d      = sdo;
        done_d     = 1'b0;

        unique case (state)
            IDLE: begin
                cs_d   = 1'b0;
                sclk_d = 1'b0;
                if (start) begin
                    tx_shift_d = tx_data;
                    sdo_d      = tx_data[WIDTH-1];
                    cs_d       = 1'b1;
                    div_cnt_d  = '0;
                    edge_cnt_d = '0;
                    state_d    = SETUP;
                end
            end
            SETUP: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    state_d   = XFER;
                end else begin
                    div_cnt_d = div_cnt + DIV_W'(1);
                end
            end
            XFER: begin
                if (div_last) begin
                    div_cnt_d  = '0;
                    sclk_d     = ~sclk;
                    edge_cnt_d = edge_cnt + EDGE_W'(1);
                    if (!sclk) begin
                        rx_shift_d = WIDTH'({rx_shift, sdi});
                    end else if (edge_cnt == EDGE_LAST) begin
                        // Last falling edge: sdo holds, no new bit launched
                        edge_cnt_d = '0;
                        state_d    = HOLD;
                    end else begin
                        tx_shift_d = tx_next;
                        sdo_d      = tx_next[WIDTH-1];
                    end
                end else begin
                    div_cnt_d = div_cnt + DIV_W'(1);
                end
            end
            HOLD: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    cs_d      = 1'b0;
                    done_d    = 1'b1;
                    rx_data_d = rx_shift;
                    state_d   = DONE;
                end else begin
                    div_cnt_d = div_cnt + DIV_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: scoreboard of expected frames checked at done, plus
// per-scenario tasks for framing, back-to-back, ignored starts, reset and CLK_DIV=1.
module tb_spi_controller;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic       busy, done, cs, sclk, sdo, sdi;
    logic [7:0] rx_data;
    int         sdi_mode;

    logic       start_b;
    logic [3:0] tx_b;
    logic       busy_b, done_b, cs_b, sclk_b, sdo_b, sdi_b;
    logic [3:0] rx_b;

    int checks;
    int failures;

    exp_t       sb[$];
    logic [3:0] sb_b[$];

    assign sdi   = (sdi_mode == 0) ? sdo : (sdi_mode == 1);
    assign sdi_b = sdo_b;

    spi_controller #(.WIDTH(8), .CLK_DIV(2)) dut (
        .clk(clk), .reset(reset), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .cs(cs), .sclk(sclk), .sdo(sdo), .sdi(sdi)
    );

    spi_controller #(.WIDTH(4), .CLK_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .tx_data(tx_b),
        .busy(busy_b), .done(done_b), .rx_data(rx_b),
        .cs(cs_b), .sclk(sclk_b), .sdo(sdo_b), .sdi(sdi_b)
    );

    always #5 clk = ~clk;

    // Reset as seen by the DUT at the last posedge
    logic rst_q;
    always @(posedge clk) rst_q <= reset;

    // Frame monitor for the WIDTH=8 / CLK_DIV=2 instance
    int         cs_len, edges;
    logic       cs_prev, sclk_prev;
    logic [7:0] cap;
    always @(negedge clk) begin
        exp_t e;
        if (rst_q !== 1'b1) begin
            cs_len = 0; edges = 0; cs_prev = 0; sclk_prev = 0; cap = '0;
        end else begin
            if (cs) cs_len++;
            if (sclk != sclk_prev) edges++;
            if (sclk && !sclk_prev) cap = {cap[6:0], sdo};
            if (!cs && cs_prev) begin
                checks++;
                if (cs_len != 36) begin
                    failures++;
                    $display("FAIL cs_high_len got=%0d exp=36", cs_len);
                end
                checks++;
                if (edges != 16) begin
                    failures++;
                    $display("FAIL sclk_edges got=%0d exp=16", edges);
                end
                checks++;
                if (done !== 1'b1) begin
                    failures++;
                    $display("FAIL done_first_cs_low got=%b exp=1", done);
                end
                cs_len = 0; edges = 0;
            end
            if (done === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done rx=%h", rx_data);
                end else begin
                    e = sb.pop_front();
                    if (rx_data !== e.rx) begin
                        failures++;
                        $display("FAIL rx_data got=%h exp=%h", rx_data, e.rx);
                    end
                    checks++;
                    if (cap !== e.tx) begin
                        failures++;
                        $display("FAIL sdo_bits got=%h exp=%h", cap, e.tx);
                    end
                end
            end
            cs_prev = cs; sclk_prev = sclk;
        end
    end

    // Frame monitor for the WIDTH=4 / CLK_DIV=1 instance
    int   cs_len_b, gap_b;
    logic cs_prev_b, sclk_prev_b, first_b;
    always @(negedge clk) begin
        logic [3:0] eb;
        if (rst_q !== 1'b1) begin
            cs_len_b = 0; gap_b = 0; cs_prev_b = 0; sclk_prev_b = 0; first_b = 1;
        end else begin
            if (cs_b) cs_len_b++;
            gap_b++;
            if (sclk_b && !sclk_prev_b) begin
                if (!first_b) begin
                    checks++;
                    if (gap_b != 2) begin
                        failures++;
                        $display("FAIL b_sclk_period got=%0d exp=2", gap_b);
                    end
                end
                first_b = 0; gap_b = 0;
            end
            if (!cs_b && cs_prev_b) begin
                checks++;
                if (cs_len_b != 10) begin
                    failures++;
                    $display("FAIL b_cs_high_len got=%0d exp=10", cs_len_b);
                end
                checks++;
                if (done_b !== 1'b1) begin
                    failures++;
                    $display("FAIL b_done_first_cs_low got=%b exp=1", done_b);
                end
                cs_len_b = 0; first_b = 1;
            end
            if (done_b === 1'b1) begin
                checks++;
                if (sb_b.size() == 0) begin
                    failures++;
                    $display("FAIL b_unexpected_done rx=%h", rx_b);
                end else begin
                    eb = sb_b.pop_front();
                    if (rx_b !== eb) begin
                        failures++;
                        $display("FAIL b_rx_data got=%h exp=%h", rx_b, eb);
                    end
                end
            end
            cs_prev_b = cs_b; sclk_prev_b = sclk_b;
        end
    end

    task automatic wait_done(input int bound);
        bit got = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout bound=%0d", bound);
        end
    endtask

    task automatic run_frame(input logic [7:0] tx, input logic [7:0] rx);
        @(negedge clk);
        tx_data = tx;
        start   = 1'b1;
        sb.push_back('{tx: tx, rx: rx});
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_done got=%b exp=0", busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({cs, sclk, sdo, busy, done, rx_data} !== 13'h0) begin
            failures++;
            $display("FAIL reset_a got cs=%b sclk=%b sdo=%b busy=%b done=%b rx=%h exp all 0",
                     cs, sclk, sdo, busy, done, rx_data);
        end
        checks++;
        if ({cs_b, sclk_b, sdo_b, busy_b, done_b, rx_b} !== 9'h0) begin
            failures++;
            $display("FAIL reset_b got cs=%b sclk=%b sdo=%b busy=%b done=%b rx=%h exp all 0",
                     cs_b, sclk_b, sdo_b, busy_b, done_b, rx_b);
        end
        reset = 1'b1;
    endtask

    task automatic test_loopback();
        sdi_mode = 0;
        run_frame(8'hA5, 8'hA5);
    endtask

    task automatic test_sdi_tied();
        sdi_mode = 1;
        run_frame(8'h00, 8'hFF);
        sdi_mode = 2;
        run_frame(8'hFF, 8'h00);
        sdi_mode = 0;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        tx_data = 8'h3C;
        start   = 1'b1;
        sb.push_back('{tx: 8'h3C, rx: 8'h3C});
        sb.push_back('{tx: 8'hC3, rx: 8'hC3});
        @(negedge clk);
        tx_data = 8'hC3;
        wait_done(100);
        @(negedge clk);
        checks++;
        if (cs !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap_cycle2 cs got=%b exp=0", cs);
        end
        @(negedge clk);
        checks++;
        if (cs !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart cs got=%b exp=1", cs);
        end
        start = 1'b0;
        wait_done(100);
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int busy_hits = 0;
        @(negedge clk);
        tx_data = 8'hA5;
        start   = 1'b1;
        sb.push_back('{tx: 8'hA5, rx: 8'hA5});
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        tx_data = 8'hFF;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (50) begin
            if (busy) busy_hits++;
            @(negedge clk);
        end
        checks++;
        if (busy_hits != 0) begin
            failures++;
            $display("FAIL ignored_start busy_cycles got=%0d exp=0", busy_hits);
        end
    endtask

    task automatic test_reset_mid();
        int done_hits = 0;
        @(negedge clk);
        tx_data = 8'h77;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || cs !== 1'b1) begin
            failures++;
            $display("FAIL mid_xfer_active busy=%b cs=%b exp 1", busy, cs);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({cs, sclk, sdo, busy, done, rx_data} !== 13'h0) begin
            failures++;
            $display("FAIL reset_mid got cs=%b sclk=%b sdo=%b busy=%b done=%b rx=%h exp all 0",
                     cs, sclk, sdo, busy, done, rx_data);
        end
        repeat (2) begin
            @(negedge clk);
            if (done) done_hits++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) done_hits++;
        end
        checks++;
        if (done_hits != 0) begin
            failures++;
            $display("FAIL reset_no_done got=%0d exp=0", done_hits);
        end
        run_frame(8'h5A, 8'h5A);
    endtask

    task automatic test_div1();
        bit got = 0;
        @(negedge clk);
        tx_b    = 4'h9;
        start_b = 1'b1;
        sb_b.push_back(4'h9);
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done_b === 1'b1) begin
                got = 1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL b_done_timeout");
        end
        @(negedge clk);
        checks++;
        if (busy_b !== 1'b0) begin
            failures++;
            $display("FAIL b_busy_after_done got=%b exp=0", busy_b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        clk      = 1'b0;
        reset    = 1'b0;
        start    = 1'b0;
        tx_data  = '0;
        start_b  = 1'b0;
        tx_b     = '0;
        sdi_mode = 0;
        checks   = 0;
        failures = 0;

        test_reset();
        test_loopback();
        test_sdi_tied();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid();
        test_div1();

        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0 || sb_b.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d/%0d exp=0", sb.size(), sb_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
